// File: rtl/linebuf_ctrl.sv
// Line-buffer feed controller: pads each image line with zeros, then flushes
// HALF zero lines so a 7x7 window can drain the last image rows.
`timescale 1ns/1ps
module linebuf_ctrl #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PAD   = 19,
    parameter int unsigned HALF  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       in_ready,
    output logic       lb_en,
    output logic [7:0] lb_din,
    output logic       win_valid,
    output logic [9:0] ctr_col,
    output logic [9:0] ctr_row,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CW   = 10;
    localparam int unsigned LINE = IMG_W + 2 * PAD;
    localparam int unsigned ROWS = IMG_H + HALF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAD_L,
        S_ACTIVE,
        S_PAD_R,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_pos;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   w_pos_nxt;
    logic [CW-1:0]   w_row_nxt;
    logic            w_emit;
    logic [7:0]      w_din;
    logic            w_win;

    // State, counters and the registered line-buffer outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pos     <= '0;
            r_row     <= '0;
            lb_en     <= 1'b0;
            lb_din    <= '0;
            win_valid <= 1'b0;
            ctr_col   <= '0;
            ctr_row   <= '0;
        end else begin
            r_state   <= w_next;
            r_pos     <= w_pos_nxt;
            r_row     <= w_row_nxt;
            lb_en     <= w_emit;
            win_valid <= w_win;
            if (w_emit) begin
                lb_din  <= w_din;
                ctr_col <= r_pos - CW'(PAD + HALF);
                ctr_row <= r_row - CW'(HALF);
            end
        end
    end

    // Next state, counter updates and the element emitted this cycle
    always_comb begin
        w_next    = r_state;
        w_pos_nxt = r_pos;
        w_row_nxt = r_row;
        w_emit    = 1'b0;
        w_din     = '0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next    = S_PAD_L;
                    w_pos_nxt = '0;
                    w_row_nxt = '0;
                end
            end
            S_PAD_L: begin
                w_emit    = 1'b1;
                w_pos_nxt = r_pos + CW'(1);
                if (r_pos == CW'(PAD - 1)) w_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (pix_valid) begin
                    w_emit    = 1'b1;
                    w_din     = pix_data;
                    w_pos_nxt = r_pos + CW'(1);
                    if (r_pos == CW'(PAD + IMG_W - 1)) w_next = S_PAD_R;
                end
            end
            S_PAD_R: begin
                w_emit = 1'b1;
                if (r_pos == CW'(LINE - 1)) begin
                    w_pos_nxt = '0;
                    w_row_nxt = r_row + CW'(1);
                    w_next    = (r_row + CW'(1) < CW'(IMG_H)) ? S_PAD_L : S_FLUSH;
                end else begin
                    w_pos_nxt = r_pos + CW'(1);
                end
            end
            S_FLUSH: begin
                w_emit = 1'b1;
                if (r_pos == CW'(LINE - 1)) begin
                    w_pos_nxt = '0;
                    if (r_row == CW'(ROWS - 1)) w_next = S_DONE;
                    else                        w_row_nxt = r_row + CW'(1);
                end else begin
                    w_pos_nxt = r_pos + CW'(1);
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_win = w_emit && (r_row >= CW'(HALF)) && (r_pos >= CW'(PAD + HALF)) &&
                   (r_pos < CW'(PAD + HALF + IMG_W));

    // Moore decodes of the state register
    assign in_ready   = (r_state == S_ACTIVE);
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);

endmodule
